// File: rtl/ahb3lite_sram_slave.sv
// -----------------------------------------------------------------------------
// ahb3lite_sram_slave
//
// AHB3-Lite leaf slave in front of an on-chip, word-addressed SRAM array.
// Supports a configurable data width, memory depth and number of wait states.
// Writes update only the byte lanes the transfer selects. Illegal transfers
// get a two-cycle ERROR response. A read accepted on the same edge that a
// write to the same word completes returns the merged, freshly written word.
//
// Parameters
//   HADDR_SIZE  : address bus width
//   HDATA_SIZE  : data bus width (32, 64 or 128)
//   MEM_DEPTH   : number of HDATA_SIZE-wide words
//   WAIT_STATES : HREADYOUT-low cycles per OKAY data phase (0..15)
//
// Ports
//   HCLK       in   clock
//   HRESETn    in   synchronous active-low reset
//   HSEL       in   slave select from the decoder
//   HADDR      in   transfer address
//   HWDATA     in   write data (data phase)
//   HRDATA     out  read data, held when no read completes
//   HWRITE     in   1 = write
//   HSIZE      in   transfer size
//   HBURST     in   burst type (ignored, every beat carries its own address)
//   HPROT      in   protection (ignored)
//   HTRANS     in   transfer type
//   HMASTLOCK  in   lock (ignored)
//   HREADY     in   bus ready
//   HREADYOUT  out  slave ready
//   HRESP      out  0 = OKAY, 1 = ERROR
// -----------------------------------------------------------------------------
module ahb3lite_sram_slave #(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  // AHB3-Lite encodings used by this slave
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  localparam int BYTES     = HDATA_SIZE / 8;
  localparam int BYTE_BITS = $clog2(BYTES);
  localparam int AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int WIDX_W    = HADDR_SIZE - BYTE_BITS;

  localparam logic [WIDX_W-1:0] DEPTH_L   = WIDX_W'(MEM_DEPTH);
  localparam logic [2:0]        MAX_SIZE  = 3'(BYTE_BITS);
  localparam logic [3:0]        WAIT_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  // Byte-lane enables for a transfer of 2**size bytes starting at lane 'off'
  function automatic logic [BYTES-1:0] lane_mask(input logic [BYTE_BITS-1:0] off,
                                                 input logic [2:0]           size);
    logic [BYTES-1:0] m;
    int lo;
    int n;
    lo = int'(off);
    n  = int'(32'd1 << size);
    m  = '0;
    for (int i = 0; i < BYTES; i++) begin
      m[i] = (i >= lo) && (i < lo + n);
    end
    return m;
  endfunction

  // Expand per-byte enables into a per-bit mask
  function automatic logic [HDATA_SIZE-1:0] lane_bits(input logic [BYTES-1:0] m);
    logic [HDATA_SIZE-1:0] b;
    b = '0;
    for (int i = 0; i < BYTES; i++) begin
      b[i*8 +: 8] = {8{m[i]}};
    end
    return b;
  endfunction

  // Registered state
  state_t                     state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic                       dp_q, dp_d;          // OKAY data phase outstanding
  logic                       wr_q, wr_d;
  logic [2:0]                 size_q, size_d;
  logic [BYTE_BITS+AW-1:0]    addr_q, addr_d;
  logic [HDATA_SIZE-1:0]      hrdata_q, hrdata_d;
  logic                       hreadyout_q, hreadyout_d;
  logic                       hresp_q, hresp_d;
  logic [HDATA_SIZE-1:0]      mem_q [MEM_DEPTH];

  // Combinational helpers
  logic                       accept_s;
  logic                       err_s;
  logic [6:0]                 align_mask_s;
  logic                       complete_s;
  logic                       wr_en_s;
  logic [AW-1:0]              dp_idx_s;
  logic [AW-1:0]              rd_idx_s;
  logic [HDATA_SIZE-1:0]      wr_bits_s;
  logic [HDATA_SIZE-1:0]      wr_word_s;
  logic [HDATA_SIZE-1:0]      rd_word_s;
  logic                       ld_now_s;
  logic                       ld_wait_s;
  logic                       unused_s;

  assign unused_s = ^{HBURST, HPROT, HMASTLOCK};

  // Address-phase decode: accept and error classification
  always_comb begin
    accept_s = HSEL && HREADY &&
               ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ)) &&
               ((state_q == ST_IDLE) || (state_q == ST_ERR2));
    // 7'd1 << 7 wraps to zero, so the mask saturates to all ones for size 7
    align_mask_s = (7'd1 << HSIZE) - 7'd1;
    err_s = (HSIZE > MAX_SIZE) ||
            (|(HADDR[6:0] & align_mask_s)) ||
            (HADDR[HADDR_SIZE-1:BYTE_BITS] >= DEPTH_L);
  end

  // Data-phase datapath: write merge, read select with same-word forwarding
  always_comb begin
    complete_s = (state_q == ST_IDLE) && dp_q && HREADY;
    wr_en_s    = complete_s && wr_q;
    dp_idx_s   = addr_q[BYTE_BITS +: AW];
    rd_idx_s   = HADDR[BYTE_BITS +: AW];
    wr_bits_s  = lane_bits(lane_mask(addr_q[BYTE_BITS-1:0], size_q));
    wr_word_s  = (mem_q[dp_idx_s] & ~wr_bits_s) | (HWDATA & wr_bits_s);
    // A write retiring on this edge has not reached the array yet
    if (wr_en_s && (dp_idx_s == rd_idx_s)) begin
      rd_word_s = wr_word_s;
    end else begin
      rd_word_s = mem_q[rd_idx_s];
    end
    // Zero-wait reads load on the accept edge; waited reads load leaving WAIT
    ld_now_s  = accept_s && !err_s && !HWRITE && (WAIT_STATES == 0);
    ld_wait_s = (state_q == ST_WAIT) && (cnt_q == 4'd0) && !wr_q;
    if (ld_now_s) begin
      hrdata_d = rd_word_s;
    end else if (ld_wait_s) begin
      hrdata_d = mem_q[dp_idx_s];
    end else begin
      hrdata_d = hrdata_q;
    end
  end

  // Transfer bookkeeping: latch address-phase controls, track the data phase
  always_comb begin
    if (accept_s) begin
      addr_d = HADDR[BYTE_BITS+AW-1:0];
      size_d = HSIZE;
      wr_d   = HWRITE;
    end else begin
      addr_d = addr_q;
      size_d = size_q;
      wr_d   = wr_q;
    end
    if (accept_s && !err_s) begin
      dp_d = 1'b1;
    end else if (complete_s) begin
      dp_d = 1'b0;
    end else begin
      dp_d = dp_q;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (accept_s) begin
          if (err_s) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from the next state so they leave a flop
  always_comb begin
    case (state_d)
      ST_IDLE: begin
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
      end
      ST_WAIT: begin
        hreadyout_d = 1'b0;
        hresp_d     = HRESP_OKAY;
      end
      ST_ERR1: begin
        hreadyout_d = 1'b0;
        hresp_d     = HRESP_ERROR;
      end
      ST_ERR2: begin
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_ERROR;
      end
      default: begin
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      dp_q        <= 1'b0;
      wr_q        <= 1'b0;
      size_q      <= 3'd0;
      addr_q      <= '0;
      hrdata_q    <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dp_q        <= dp_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      hrdata_q    <= hrdata_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  // SRAM array write port; contents survive reset, pending writes do not
  always_ff @(posedge HCLK) begin
    if (HRESETn && wr_en_s) begin
      mem_q[dp_idx_s] <= wr_word_s;
    end
  end

  assign HRDATA    = hrdata_q;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_ahb3lite_sram_slave
//
// Self-checking bench for ahb3lite_sram_slave. Two instances share one set of
// master-side inputs: u_w0 (WAIT_STATES=0) and u_w3 (WAIT_STATES=3). HREADY is
// taken from whichever instance is under test, as an interconnect would.
// Zero-wait behaviour is a table of one-cycle vectors; wait states and reset
// during a waited write are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_ahb3lite_sram_slave;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NS   = 2'b10;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hmastlock;
  logic        hready;
  logic        hready_en;
  logic        use_w3;

  logic [31:0] rdata0, rdata1;
  logic        ro0, ro1, resp0, resp1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 hclk = ~hclk;

  assign hready = hready_en & (use_w3 ? ro1 : ro0);

  ahb3lite_sram_slave #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_w0 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rdata0), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(hready), .HREADYOUT(ro0), .HRESP(resp0)
  );

  ahb3lite_sram_slave #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u_w3 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rdata1), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADY(hready), .HREADYOUT(ro1), .HRESP(resp1)
  );

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;   // data phase of the previous vector's transfer
    logic        rin;     // HREADY enable
    logic        e_rdy;
    logic        e_resp;
    logic        chk;     // compare HRDATA
    logic [31:0] e_rdata;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

  function automatic vec_t v(input logic sel, input logic [1:0] trans, input logic wr,
                             input logic [2:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic rin, input logic e_rdy,
                             input logic e_resp, input logic chk, input logic [31:0] e_rdata);
    vec_t r;
    r.sel = sel; r.trans = trans; r.wr = wr; r.size = size; r.addr = addr;
    r.wdata = wdata; r.rin = rin; r.e_rdy = e_rdy; r.e_resp = e_resp;
    r.chk = chk; r.e_rdata = e_rdata;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // One transfer on the WAIT_STATES=3 slave; returns read data and wait count
  task automatic w3_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output int waits);
    hsel = 1'b1; htrans = T_NS; hwrite = wr; hsize = 3'd2; haddr = addr;
    tick();
    htrans = T_IDLE; hwrite = 1'b0; hwdata = wdata;
    waits = 0;
    while (ro1 === 1'b0 && waits < 10) begin
      check("w3_wait_resp", 32'(resp1), 32'd0);
      waits++;
      tick();
    end
    check("w3_done_rdy", 32'(ro1), 32'd1);
    check("w3_done_resp", 32'(resp1), 32'd0);
    rd = rdata1;
    tick();
  endtask

  initial begin
    logic [31:0] rd;
    int          waits;

    // Vector table, WAIT_STATES=0 slave
    vecs[0]  = v(1'b1, T_NS,   1'b1, 3'd2, 32'h00, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
    vecs[1]  = v(1'b1, T_NS,   1'b1, 3'd2, 32'h10, 32'h01234567, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
    vecs[2]  = v(1'b1, T_NS,   1'b0, 3'd2, 32'h10, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
    vecs[3]  = v(1'b1, T_IDLE, 1'b0, 3'd2, 32'h00, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
    vecs[4]  = v(1'b1, T_NS,   1'b0, 3'd2, 32'h10, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
    vecs[5]  = v(1'b1, T_NS,   1'b1, 3'd2, 32'h10, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
    vecs[6]  = v(1'b1, T_NS,   1'b1, 3'd0, 32'h13, 32'h11223344, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
    vecs[7]  = v(1'b1, T_NS,   1'b0, 3'd2, 32'h10, 32'hAA000000, 1'b1, 1'b1, 1'b0, 1'b1, 32'hAA223344);
    vecs[8]  = v(1'b1, T_IDLE, 1'b0, 3'd2, 32'h00, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'hAA223344);
    vecs[9]  = v(1'b1, T_NS,   1'b0, 3'd2, 32'h00, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'h01234567);
    vecs[10] = v(1'b1, T_NS,   1'b0, 3'd2, 32'h10, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'hAA223344);
    vecs[11] = v(1'b1, T_NS,   1'b1, 3'd2, 32'h20, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'hAA223344);
    vecs[12] = v(1'b1, T_NS,   1'b0, 3'd2, 32'h20, 32'h5A5A5A5A, 1'b1, 1'b1, 1'b0, 1'b1, 32'h5A5A5A5A);
    vecs[13] = v(1'b1, T_NS,   1'b1, 3'd1, 32'h22, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'h5A5A5A5A);
    vecs[14] = v(1'b1, T_IDLE, 1'b0, 3'd2, 32'h00, 32'hC0DE0000, 1'b1, 1'b1, 1'b0, 1'b1, 32'h5A5A5A5A);
    vecs[15] = v(1'b1, T_NS,   1'b0, 3'd2, 32'h20, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'hC0DE5A5A);
    vecs[16] = v(1'b1, T_BUSY, 1'b0, 3'd2, 32'h00, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'hC0DE5A5A);
    vecs[17] = v(1'b0, T_NS,   1'b1, 3'd2, 32'h10, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'hC0DE5A5A);
    vecs[18] = v(1'b1, T_IDLE, 1'b0, 3'd2, 32'h00, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 32'hC0DE5A5A);
    vecs[19] = v(1'b1, T_NS,   1'b1, 3'd2, 32'h10, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'hC0DE5A5A);
    vecs[20] = v(1'b1, T_IDLE, 1'b0, 3'd2, 32'h00, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 32'hC0DE5A5A);
    vecs[21] = v(1'b1, T_NS,   1'b0, 3'd2, 32'h10, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'hAA223344);
    vecs[22] = v(1'b1, T_NS,   1'b1, 3'd2, 32'h02, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    vecs[23] = v(1'b1, T_IDLE, 1'b0, 3'd2, 32'h00, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    vecs[24] = v(1'b1, T_NS,   1'b1, 3'd3, 32'h10, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    vecs[25] = v(1'b1, T_IDLE, 1'b0, 3'd2, 32'h00, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    vecs[26] = v(1'b1, T_NS,   1'b1, 3'd2, 32'h400, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    vecs[27] = v(1'b1, T_IDLE, 1'b0, 3'd2, 32'h00, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    vecs[28] = v(1'b1, T_NS,   1'b0, 3'd2, 32'h00, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 32'h01234567);
    vecs[29] = v(1'b1, T_NS,   1'b0, 3'd2, 32'h10, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'hAA223344);
    vecs[30] = v(1'b1, T_NS,   1'b0, 3'd2, 32'h20, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'hC0DE5A5A);
    vecs[31] = v(1'b1, T_IDLE, 1'b0, 3'd2, 32'h00, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 32'hC0DE5A5A);

    hresetn = 1'b0; hsel = 1'b0; haddr = 32'h0; hwdata = 32'h0; hwrite = 1'b0;
    hsize = 3'd2; hburst = 3'd0; hprot = 4'd0; htrans = T_IDLE; hmastlock = 1'b0;
    hready_en = 1'b1; use_w3 = 1'b0;

    // Reset state of both instances
    tick();
    tick();
    check("rst_w0_rdy",   32'(ro0),   32'd1);
    check("rst_w0_resp",  32'(resp0), 32'd0);
    check("rst_w0_rdata", rdata0,     32'd0);
    check("rst_w3_rdy",   32'(ro1),   32'd1);
    check("rst_w3_resp",  32'(resp1), 32'd0);
    check("rst_w3_rdata", rdata1,     32'd0);
    hresetn = 1'b1;

    // Zero-wait vectors
    for (int i = 0; i < NV; i++) begin
      hsel = vecs[i].sel; htrans = vecs[i].trans; hwrite = vecs[i].wr;
      hsize = vecs[i].size; haddr = vecs[i].addr; hwdata = vecs[i].wdata;
      hready_en = vecs[i].rin;
      tick();
      check($sformatf("vec%0d_rdy", i),  32'(ro0),   32'(vecs[i].e_rdy));
      check($sformatf("vec%0d_resp", i), 32'(resp0), 32'(vecs[i].e_resp));
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_rdata", i), rdata0, vecs[i].e_rdata);
      end
    end

    // WAIT_STATES=3 instance
    use_w3 = 1'b1; hready_en = 1'b1; hsel = 1'b0; htrans = T_IDLE;
    hresetn = 1'b0;
    tick();
    hresetn = 1'b1;
    check("w3_rst_rdy", 32'(ro1), 32'd1);

    w3_xfer(1'b1, 32'h40, 32'h0BADF00D, rd, waits);
    check("w3_wr_waits", 32'(waits), 32'd3);
    w3_xfer(1'b0, 32'h40, 32'h0, rd, waits);
    check("w3_rd_waits", 32'(waits), 32'd3);
    check("w3_rd_data", rd, 32'h0BADF00D);

    // IDLE and BUSY get zero-wait OKAY
    hsel = 1'b1; htrans = T_IDLE;
    tick();
    check("w3_idle_rdy",  32'(ro1),   32'd1);
    check("w3_idle_resp", 32'(resp1), 32'd0);
    htrans = T_BUSY;
    tick();
    check("w3_busy_rdy",  32'(ro1),   32'd1);
    check("w3_busy_resp", 32'(resp1), 32'd0);
    htrans = T_IDLE;
    tick();
    check("w3_busy2_rdy", 32'(ro1), 32'd1);

    // Reset while a write waits: write dropped, outputs back to reset values
    hsel = 1'b1; htrans = T_NS; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h40;
    tick();
    check("w3_mid_wait_rdy", 32'(ro1), 32'd0);
    htrans = T_IDLE; hwrite = 1'b0; hwdata = 32'hFFFF0000;
    hresetn = 1'b0;
    tick();
    hresetn = 1'b1;
    check("w3_midrst_rdy",   32'(ro1),   32'd1);
    check("w3_midrst_resp",  32'(resp1), 32'd0);
    check("w3_midrst_rdata", rdata1,     32'd0);
    tick();
    tick();
    w3_xfer(1'b0, 32'h40, 32'h0, rd, waits);
    check("w3_post_rst_waits", 32'(waits), 32'd3);
    check("w3_post_rst_data",  rd,         32'h0BADF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb3lite_sram_slave.md
Name: ahb3lite_sram_slave

Overview:
Parametrised AHB3-Lite slave fronting an on-chip word-addressed SRAM array, built on the team's AHB3-Lite constant package (HTRANS/HSIZE/HRESP encodings).
- Successor to the fixed single-width, zero-wait memory slaves.
- Adds configurable data width, memory depth and wait states.
- Adds byte-lane writes, two-cycle ERROR response, and read-after-write forwarding.
- Sits behind the AHB3-Lite interconnect decoder as a leaf slave.

Parameters:
- HADDR_SIZE, 32, address bus width.
- HDATA_SIZE, 32, data bus width; legal values 32, 64 or 128.
- MEM_DEPTH, 256, number of HDATA_SIZE-wide words.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY data phase; legal range 0..15.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  synchronous active-low reset.
- HSEL  in  1  slave select from decoder.
- HADDR  in  HADDR_SIZE  transfer address.
- HWDATA  in  HDATA_SIZE  write data (data phase).
- HRDATA  out  HDATA_SIZE  read data.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size.
- HBURST  in  3  burst type; ignored, every beat carries its own HADDR.
- HPROT  in  4  protection; ignored.
- HTRANS  in  2  transfer type.
- HMASTLOCK  in  1  ignored.
- HREADY  in  1  bus ready (previous transfer complete).
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  OKAY=0 / ERROR=1.

Behaviour:
- Reset: one clock, synchronous on HCLK rising edge with HRESETn=0.
  - Reset values: HREADYOUT=1, HRESP=OKAY, HRDATA=0, state=IDLE, wait counter=0.
  - SRAM contents are not reset.
- Accept: a transfer is accepted on an edge where HSEL & HREADY & HTRANS∈{NONSEQ,SEQ}. At that edge latch HADDR, HSIZE and HWRITE.
- IDLE/BUSY, or HSEL=0: no action; next data phase is OKAY with zero wait.
- Error check at accept. A transfer is an error if any of:
  - 8<<HSIZE > HDATA_SIZE;
  - HADDR is not aligned to the transfer size;
  - word index HADDR/(HDATA_SIZE/8) >= MEM_DEPTH.
- States: IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=OKAY. On accept:
    - error → ERR1;
    - else WAIT_STATES>0 → WAIT, counter=WAIT_STATES-1;
    - else stay in IDLE; the data phase completes the next cycle.
  - WAIT: HREADYOUT=0, HRESP=OKAY. Counter decrements each cycle; at 0 → IDLE, where the data phase completes with HREADYOUT=1.
  - ERR1: HREADYOUT=0, HRESP=ERROR → ERR2.
  - ERR2: HREADYOUT=1, HRESP=ERROR → IDLE. A new transfer may be accepted in this cycle and follows the normal rules.
- Wait states apply to OKAY transfers only; errors are always exactly two cycles.
- Write:
  - HWDATA is sampled on the completing edge (HREADYOUT=1, non-error).
  - Only the byte lanes selected by the latched address low bits and size are written.
  - Erroring transfers never write.
- Read:
  - HRDATA is presented with HREADYOUT=1 in the completing cycle, full bus width, all lanes driven.
  - HRDATA holds its value when no read completes.
  - HRDATA is unspecified (held) during ERROR cycles.
- RAW forwarding: if a read is accepted on the same edge a write completes to the same word, the read returns the merged data (new written lanes, old others). No stale data is permitted.
- Back-to-back: with WAIT_STATES=0, one transfer completes per cycle with pipelined address/data phases.
- Reset mid-transfer: the pending write is discarded and all outputs return to reset values the next cycle.
- HREADY low while HREADYOUT=1 (another slave stalling): no accept, state held.

Test Plan:
- WAIT_STATES=0, HDATA_SIZE=32: write word 0xDEADBEEF @0x10, then read @0x10 → HRDATA=0xDEADBEEF one cycle after the read address phase, HREADYOUT never low.
- Byte write 0xAA @0x13 over 0x11223344 @0x10, then word read → 0xAA223344.
- Back-to-back write 0x5A5A5A5A @0x20 immediately followed by read @0x20 → read returns 0x5A5A5A5A via forwarding.
- Size and address errors: HSIZE=WORD @0x02 (unaligned), HSIZE=DWORD on 32-bit bus, address 4*MEM_DEPTH →
  - each gives HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1;
  - memory unchanged.
- WAIT_STATES=3: single read → exactly 3 HREADYOUT=0 cycles, then data with OKAY; IDLE/BUSY transfers → zero-wait OKAY.
- Assert HRESETn=0 during WAIT of a write → HREADYOUT=1, HRESP=0, HRDATA=0 next cycle; subsequent read of that address returns old data.
